// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter in front of a single-port synchronous SRAM.
//   Instruction fetch (IF, read-only) and data memory (DM, read/write)
//   compete for the port. DM wins by default. A starvation counter forces
//   an IF grant after STARVE_MAX consecutive DM grants while IF waits.
//   Grants are combinational: the winner's address and controls reach the
//   SRAM in the grant cycle. A one-entry response register routes sram_do
//   back to the owner one cycle later.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req, if_addr          IF read request and word address
//   dm_req, dm_web, dm_bweb,
//   dm_addr, dm_wdata        DM request, active-low write enable and bit mask,
//                            word address, write data
//   if_gnt, dm_gnt           request accepted this cycle
//   if_stall, dm_stall       request pending but not granted
//   if_rvalid, if_rdata      IF response (read data), one cycle after grant
//   dm_rvalid, dm_rdata      DM response (read data or write ack)
//   sram_ceb, sram_web,
//   sram_bweb, sram_a,
//   sram_di                  SRAM controls (active-low), address, write data
//   sram_do                  SRAM read data, one cycle after the address
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [13:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_web,
    input  logic [31:0] dm_bweb,
    input  logic [13:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        if_gnt,
    output logic        dm_gnt,
    output logic        if_rvalid,
    output logic        dm_rvalid,
    output logic [31:0] if_rdata,
    output logic [31:0] dm_rdata,
    output logic        if_stall,
    output logic        dm_stall,
    output logic        sram_ceb,
    output logic        sram_web,
    output logic [31:0] sram_bweb,
    output logic [13:0] sram_a,
    output logic [31:0] sram_di,
    input  logic [31:0] sram_do
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          resp_valid;
    owner_t        resp_owner;

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    // Grant decision. Held at zero during reset so the SRAM sees no access.
    // NOTE: every signal assigned in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst) begin
            if_gnt = if_req && (!dm_req || starved);
            dm_gnt = dm_req && !if_gnt;
        end
    end

    assign if_stall = if_req & ~if_gnt;
    assign dm_stall = dm_req & ~dm_gnt;

    // SRAM port: idle unless a grant is issued; IF is always a read.
    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_bweb = '1;
        sram_a    = '0;
        sram_di   = '0;
        if (dm_gnt) begin
            sram_ceb  = 1'b0;
            sram_web  = dm_web;
            sram_bweb = dm_bweb;
            sram_a    = dm_addr;
            sram_di   = dm_wdata;
        end else if (if_gnt) begin
            sram_ceb  = 1'b0;
            sram_a    = if_addr;
        end
    end

    // Starvation counter and response register. Reset discards any
    // response still pending, so a pre-reset grant never returns.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            resp_valid <= 1'b0;
            resp_owner <= OWN_IF;
        end else begin
            resp_valid <= if_gnt | dm_gnt;
            resp_owner <= dm_gnt ? OWN_DM : OWN_IF;
            if (!if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (dm_gnt && !starved) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

    assign if_rvalid = resp_valid && (resp_owner == OWN_IF);
    assign dm_rvalid = resp_valid && (resp_owner == OWN_DM);
    assign if_rdata  = if_rvalid ? sram_do : '0;
    assign dm_rdata  = dm_rvalid ? sram_do : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter with a behavioural SRAM and a reference model
//   (priority rule, starvation rule, word-addressed shadow memory).
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [13:0] if_addr;
    logic        dm_req;
    logic        dm_web;
    logic [31:0] dm_bweb;
    logic [13:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_stall, dm_stall;
    logic [31:0] if_rdata, dm_rdata;
    logic        sram_ceb, sram_web;
    logic [31:0] sram_bweb, sram_di;
    logic [13:0] sram_a;
    logic [31:0] sram_do;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_web(dm_web), .dm_bweb(dm_bweb),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .if_gnt(if_gnt), .dm_gnt(dm_gnt),
        .if_rvalid(if_rvalid), .dm_rvalid(dm_rvalid),
        .if_rdata(if_rdata), .dm_rdata(dm_rdata),
        .if_stall(if_stall), .dm_stall(dm_stall),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
        .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
    );

    always #5 clk = ~clk;

    // Power-on contents of every word; 0x0010 holds a known value.
    function automatic logic [31:0] init_pat(input logic [13:0] a);
        if (a == 14'h0010) return 32'hDEADBEEF;
        return (32'h9E3779B9 * {18'd0, a}) ^ 32'h0F0F0F0F;
    endfunction

    // Behavioural SRAM: one-cycle read latency, active-low bit mask.
    logic [31:0] sram_mem [16384];
    bit          sram_wr  [16384];

    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) begin
                sram_mem[sram_a] <= ((sram_wr[sram_a] ? sram_mem[sram_a] : init_pat(sram_a)) & sram_bweb)
                                  | (sram_di & ~sram_bweb);
                sram_wr[sram_a]  <= 1'b1;
            end else begin
                sram_do <= sram_wr[sram_a] ? sram_mem[sram_a] : init_pat(sram_a);
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [16384];
    bit          ref_wr  [16384];
    int          m_starve = 0;

    // Observations from the last step, for scenario-specific checks.
    logic        obs_if_gnt, obs_dm_gnt, obs_if_stall, obs_ceb, obs_web;
    logic [31:0] obs_bweb, obs_di, obs_if_rdata, obs_dm_rdata;
    logic        obs_if_rvalid, obs_dm_rvalid;

    function automatic logic [31:0] ref_rd(input logic [13:0] a);
        return ref_wr[a] ? ref_mem[a] : init_pat(a);
    endfunction

    // One clock cycle: inputs already driven at the falling edge.
    task automatic step(input string tag);
        bit          e_if, e_dm, e_wr;
        logic [31:0] e_data;
        logic [31:0] e_bweb;
        #1;
        e_if   = if_req && (!dm_req || m_starve == STARVE_MAX);
        e_dm   = dm_req && !e_if;
        e_wr   = e_dm && !dm_web;
        e_data = '0;
        e_bweb = e_dm ? dm_bweb : 32'hFFFF_FFFF;

        obs_if_gnt = if_gnt; obs_dm_gnt = dm_gnt; obs_if_stall = if_stall;
        obs_ceb = sram_ceb; obs_web = sram_web; obs_bweb = sram_bweb; obs_di = sram_di;

        checks++;
        if (if_gnt !== e_if || dm_gnt !== e_dm) begin
            errors++;
            $display("FAIL %s gnt: got if=%b dm=%b, expected if=%b dm=%b", tag, if_gnt, dm_gnt, e_if, e_dm);
        end
        checks++;
        if (if_stall !== (if_req && !e_if) || dm_stall !== (dm_req && !e_dm)) begin
            errors++;
            $display("FAIL %s stall: got if=%b dm=%b", tag, if_stall, dm_stall);
        end
        checks++;
        if (sram_ceb !== !(e_if || e_dm) || sram_web !== !e_wr || sram_bweb !== e_bweb) begin
            errors++;
            $display("FAIL %s sram_ctl: got ceb=%b web=%b bweb=%h, expected ceb=%b web=%b bweb=%h",
                     tag, sram_ceb, sram_web, sram_bweb, !(e_if || e_dm), !e_wr, e_bweb);
        end
        if (e_if || e_dm) begin
            checks++;
            if (sram_a !== (e_dm ? dm_addr : if_addr)) begin
                errors++;
                $display("FAIL %s sram_a: got %h, expected %h", tag, sram_a, e_dm ? dm_addr : if_addr);
            end
        end
        if (e_wr) begin
            checks++;
            if (sram_di !== dm_wdata) begin
                errors++;
                $display("FAIL %s sram_di: got %h, expected %h", tag, sram_di, dm_wdata);
            end
        end

        // Reference: perform the access on the shadow memory.
        if (e_if) e_data = ref_rd(if_addr);
        if (e_dm && !e_wr) e_data = ref_rd(dm_addr);
        if (e_wr) begin
            ref_mem[dm_addr] = (ref_rd(dm_addr) & dm_bweb) | (dm_wdata & ~dm_bweb);
            ref_wr[dm_addr]  = 1'b1;
        end
        if (!if_req || e_if) m_starve = 0;
        else if (e_dm && m_starve < STARVE_MAX) m_starve++;

        @(posedge clk);
        #1;
        obs_if_rvalid = if_rvalid; obs_dm_rvalid = dm_rvalid;
        obs_if_rdata = if_rdata; obs_dm_rdata = dm_rdata;
        checks++;
        if (if_rvalid !== e_if || dm_rvalid !== e_dm) begin
            errors++;
            $display("FAIL %s rvalid: got if=%b dm=%b, expected if=%b dm=%b", tag, if_rvalid, dm_rvalid, e_if, e_dm);
        end
        checks++;
        if (if_rdata !== (e_if ? e_data : 32'h0)) begin
            errors++;
            $display("FAIL %s if_rdata: got %h, expected %h", tag, if_rdata, e_if ? e_data : 32'h0);
        end
        if (!e_wr) begin
            checks++;
            if (dm_rdata !== (e_dm ? e_data : 32'h0)) begin
                errors++;
                $display("FAIL %s dm_rdata: got %h, expected %h", tag, dm_rdata, e_dm ? e_data : 32'h0);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_web = 1'b1; dm_bweb = '1; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic check_inactive(input string tag);
        checks++;
        if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 ||
            if_rdata !== 32'h0 || dm_rdata !== 32'h0 || sram_ceb !== 1'b1 || sram_web !== 1'b1 ||
            sram_bweb !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL %s inactive: got gnt=%b%b rvalid=%b%b rdata=%h/%h ceb=%b web=%b bweb=%h",
                     tag, if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_rdata, dm_rdata, sram_ceb, sram_web, sram_bweb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        if_req = 1'b1; dm_req = 1'b1; dm_web = 1'b0;
        repeat (3) @(negedge clk);
        check_inactive("reset");
        // First grant in the very first cycle after release.
        rst = 1'b0; m_starve = 0;
        idle_inputs();
        if_req = 1'b1; if_addr = 14'h0003;
        step("first_after_reset");
        checks++;
        if (obs_if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: got if_gnt=%b, expected 1", obs_if_gnt);
        end
        idle_inputs();
    endtask

    task automatic test_if_read();
        if_req = 1'b1; if_addr = 14'h0010;
        step("if_read");
        checks++;
        if (obs_if_gnt !== 1'b1 || obs_if_rvalid !== 1'b1 || obs_if_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL if_read: got gnt=%b rvalid=%b rdata=%h, expected 1 1 deadbeef",
                     obs_if_gnt, obs_if_rvalid, obs_if_rdata);
        end
        idle_inputs();
    endtask

    task automatic test_dm_write();
        logic [31:0] exp_word;
        dm_req = 1'b1; dm_web = 1'b0; dm_bweb = 32'hFFFF0000; dm_addr = 14'h0020; dm_wdata = 32'h12345678;
        step("dm_write");
        checks++;
        if (obs_web !== 1'b0 || obs_bweb !== 32'hFFFF0000 || obs_di !== 32'h12345678 ||
            obs_dm_rvalid !== 1'b1 || obs_if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL dm_write: got web=%b bweb=%h di=%h dm_rvalid=%b if_rvalid=%b",
                     obs_web, obs_bweb, obs_di, obs_dm_rvalid, obs_if_rvalid);
        end
        idle_inputs();
        // Read back: low half written, high half preserved.
        exp_word = (init_pat(14'h0020) & 32'hFFFF0000) | 32'h00005678;
        if_req = 1'b1; if_addr = 14'h0020;
        step("dm_write_readback");
        checks++;
        if (obs_if_rdata !== exp_word) begin
            errors++;
            $display("FAIL write_readback: got %h, expected %h", obs_if_rdata, exp_word);
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        if_req = 1'b1; if_addr = 14'h0007;
        dm_req = 1'b1; dm_web = 1'b1; dm_addr = 14'h0008;
        step("collision");
        checks++;
        if (obs_dm_gnt !== 1'b1 || obs_if_gnt !== 1'b0 || obs_if_stall !== 1'b1) begin
            errors++;
            $display("FAIL collision: got dm_gnt=%b if_gnt=%b if_stall=%b, expected 1 0 1",
                     obs_dm_gnt, obs_if_gnt, obs_if_stall);
        end
        dm_req = 1'b0;
        step("collision_if_next");
        checks++;
        if (obs_if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL collision_if_next: got if_gnt=%b, expected 1", obs_if_gnt);
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        step("starve_idle");
        if_req = 1'b1; if_addr = 14'h0011;
        dm_req = 1'b1; dm_web = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dm_addr = 14'($urandom_range(0, 31));
            step("starve");
            checks++;
            // Four DM grants, then IF, repeating.
            if (obs_if_gnt !== (i % 5 == 4) || obs_dm_gnt !== (i % 5 != 4)) begin
                errors++;
                $display("FAIL starve_pattern cycle %0d: got if=%b dm=%b", i, obs_if_gnt, obs_dm_gnt);
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin
                if_req = 1'b1; if_addr = 14'(i);
            end else begin
                dm_req = 1'b1; dm_web = 1'b1; dm_addr = 14'(i + 40);
            end
            step("alternate");
            checks++;
            if (obs_ceb !== 1'b0 || obs_if_rvalid !== (i % 2 == 0) || obs_dm_rvalid !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL alternate cycle %0d: got ceb=%b if_rvalid=%b dm_rvalid=%b",
                         i, obs_ceb, obs_if_rvalid, obs_dm_rvalid);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if_req   = ($urandom_range(0, 9) < 6);
            if_addr  = 14'($urandom_range(0, 31));
            dm_req   = ($urandom_range(0, 9) < 7);
            dm_web   = $urandom_range(0, 1) == 1;
            dm_bweb  = $urandom;
            dm_addr  = 14'($urandom_range(0, 31));
            dm_wdata = $urandom;
            step("random");
        end
        idle_inputs();
    endtask

    task automatic test_reset_pending();
        dm_req = 1'b1; dm_web = 1'b1; dm_addr = 14'h0005;
        #1;
        checks++;
        if (dm_gnt !== 1'b1) begin
            errors++;
            $display("FAIL pending_grant: got dm_gnt=%b, expected 1", dm_gnt);
        end
        #1;
        rst = 1'b1;
        #1;
        check_inactive("reset_async");
        @(posedge clk);
        #1;
        check_inactive("reset_pending");
        @(negedge clk);
        check_inactive("reset_hold");
        rst = 1'b0; m_starve = 0;
        idle_inputs();
        step("post_reset_idle0");
        step("post_reset_idle1");
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_dm_write();
        test_collision();
        test_starvation();
        test_back_to_back();
        test_random();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
